np_frame_sequencer: RTL and testbench

//  Upstream feeder for the 8-pixel NeoPixel high-level controller. Game logic writes

---
 rtl/np_pkg.sv | 17 +
 rtl/np_pixel_buffer.sv | 36 +++
 rtl/np_frame_sequencer.sv | 124 ++++++++++++
 tb/tb_np_frame_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/np_pkg.sv
// Shared types and constants for the NeoPixel frame path.
// Used by the sequencer, its pixel buffer and the strand controller.
package np_pkg;

  localparam int NUM_PIXELS = 8;
  localparam int PIX_W      = 3;
  localparam int PIXEL_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GO,
    WAIT_ACK,
    WAIT_DONE
  } seq_state_t;

endpackage

// File: rtl/np_pixel_buffer.sv
// Shadow frame regfile with one write port and a parallel snapshot view.
// The snapshot forwards a same-cycle write so a commit captures it.
module np_pixel_buffer
  import np_pkg::*;
#(
  parameter int NUM_PIXELS = np_pkg::NUM_PIXELS,
  parameter int COLOR_W    = 8,
  localparam int PIX_W     = $clog2(NUM_PIXELS),
  localparam int WORD_W    = 3 * COLOR_W
) (
  input  logic                               CLOCK_50,
  input  logic                               reset_n,
  input  logic                               wr_en,
  input  logic [PIX_W-1:0]                   wr_pixel,
  input  logic [WORD_W-1:0]                  wr_data,
  output logic [NUM_PIXELS-1:0][WORD_W-1:0]  snap
);

  logic [NUM_PIXELS-1:0][WORD_W-1:0] mem;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_pixel] <= wr_data;
    end
  end

  always_comb begin
    snap = mem;
    if (wr_en) begin
      snap[wr_pixel] = wr_data;
    end
  end

endmodule

// File: rtl/np_frame_sequencer.sv
// Snapshots the shadow frame on commit and streams it into the strand
// controller, then tracks the refresh; commits mid-refresh coalesce.
module np_frame_sequencer #(
  parameter int NUM_PIXELS = np_pkg::NUM_PIXELS,
  parameter int COLOR_W    = 8,
  parameter int CNT_W      = 16,
  localparam int PIX_W     = $clog2(NUM_PIXELS)
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [PIX_W-1:0]   wr_pixel,
  input  logic [COLOR_W-1:0] wr_red,
  input  logic [COLOR_W-1:0] wr_green,
  input  logic [COLOR_W-1:0] wr_blue,
  input  logic               commit,
  input  logic               np_ready,
  output logic [COLOR_W-1:0] np_red,
  output logic [COLOR_W-1:0] np_green,
  output logic [COLOR_W-1:0] np_blue,
  output logic [PIX_W-1:0]   np_pixel,
  output logic               np_load,
  output logic               np_go,
  output logic               busy,
  output logic               pending,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [7:0]         drop_cnt
);

  import np_pkg::*;

  localparam int WORD_W = 3 * COLOR_W;

  seq_state_t                        state;
  logic [NUM_PIXELS-1:0][WORD_W-1:0] snap;
  logic [NUM_PIXELS-1:0][WORD_W-1:0] active;
  logic [PIX_W-1:0]                  idx;
  logic                              idle_like;
  logic                              in_load;
  logic                              launch;

  np_pixel_buffer #(
    .NUM_PIXELS (NUM_PIXELS),
    .COLOR_W    (COLOR_W)
  ) u_buf (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_pixel (wr_pixel),
    .wr_data  ({wr_red, wr_green, wr_blue}),
    .snap     (snap)
  );

  // Illegal encodings behave as IDLE so the block always recovers.
  assign idle_like = !(state inside {LOAD, GO, WAIT_ACK, WAIT_DONE});
  assign in_load   = (state == LOAD);
  assign launch    = idle_like && pending && np_ready;

  assign np_load  = in_load && np_ready;
  assign np_go    = (state == GO) && np_ready;
  assign np_pixel = in_load ? idx : '0;
  assign {np_red, np_green, np_blue} = in_load ? active[idx] : '0;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      active    <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      pending   <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (commit) begin
        if (pending && !launch && drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
        pending <= 1'b1;
      end else if (launch) begin
        pending <= 1'b0;
      end

      case (state)
        LOAD: begin
          if (np_ready) begin
            if (idx == PIX_W'(NUM_PIXELS - 1)) begin
              state <= GO;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        GO: begin
          if (np_ready) state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!np_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (np_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          if (launch) begin
            active    <= snap;
            idx       <= '0;
            busy      <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
            state     <= LOAD;
          end
        end
      endcase
    end
  end

  a_legal_state: assert property (
    @(posedge CLOCK_50) disable iff (!reset_n)
    state inside {IDLE, LOAD, GO, WAIT_ACK, WAIT_DONE}
  );

endmodule

// File: tb/tb_np_frame_sequencer.sv
// Scoreboard bench for np_frame_sequencer with a strand controller model.
// Directed scenarios first, then randomized writes, commits and ready stalls.
module tb_np_frame_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       wr_en    = 1'b0;
  logic [2:0] wr_pixel = '0;
  logic [7:0] wr_red   = '0;
  logic [7:0] wr_green = '0;
  logic [7:0] wr_blue  = '0;
  logic       commit   = 1'b0;
  logic       np_ready = 1'b1;
  logic [7:0] np_red, np_green, np_blue;
  logic [2:0] np_pixel;
  logic       np_load, np_go, busy, pending;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  np_frame_sequencer dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_pixel  (wr_pixel),
    .wr_red    (wr_red),
    .wr_green  (wr_green),
    .wr_blue   (wr_blue),
    .commit    (commit),
    .np_ready  (np_ready),
    .np_red    (np_red),
    .np_green  (np_green),
    .np_blue   (np_blue),
    .np_pixel  (np_pixel),
    .np_load   (np_load),
    .np_go     (np_go),
    .busy      (busy),
    .pending   (pending),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  px;
    logic [23:0] rgb;
  } load_t;

  // Reference model: what the strand should receive, frame by frame.
  logic [23:0] m_shadow [8];
  load_t       exp_load [$];
  int          exp_go = 0;
  bit          m_busy = 0;
  bit          m_pend = 0;
  int          m_loads_left = 0;
  bit          m_go_owed = 0;
  bit          m_seen_low = 0;
  int          m_frames = 0;
  int          m_drop = 0;

  always @(posedge CLOCK_50 or negedge reset_n) begin
    bit launch;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_shadow[i] = '0;
      exp_load.delete();
      exp_go = 0;
      m_busy = 0;
      m_pend = 0;
      m_loads_left = 0;
      m_go_owed = 0;
      m_seen_low = 0;
      m_frames = 0;
      m_drop = 0;
    end else begin
      launch = !m_busy && m_pend && np_ready;
      if (launch) begin
        for (int i = 0; i < 8; i++) begin
          load_t e;
          e.px  = 3'(i);
          e.rgb = m_shadow[i];
          if (wr_en && wr_pixel == 3'(i)) e.rgb = {wr_red, wr_green, wr_blue};
          exp_load.push_back(e);
        end
        exp_go++;
        m_busy = 1;
        m_loads_left = 8;
        m_go_owed = 1;
        m_seen_low = 0;
        m_frames = (m_frames + 1) % 65536;
      end else if (m_busy) begin
        if (m_loads_left > 0) begin
          if (np_ready) m_loads_left--;
        end else if (m_go_owed) begin
          if (np_ready) m_go_owed = 0;
        end else if (!m_seen_low) begin
          if (!np_ready) m_seen_low = 1;
        end else if (np_ready) begin
          m_busy = 0;
        end
      end
      if (commit) begin
        if (m_pend && !launch && m_drop < 255) m_drop++;
        m_pend = 1;
      end else if (launch) begin
        m_pend = 0;
      end
      if (wr_en) m_shadow[wr_pixel] = {wr_red, wr_green, wr_blue};
    end
  end

  // Monitor: pops the scoreboard whenever the DUT drives the strand.
  logic [23:0] cap [8];
  int          held4 = 0;

  always @(negedge CLOCK_50) begin
    if (reset_n) begin
      chk("busy", busy, m_busy);
      chk("pending", pending, m_pend);
      chk("frame_cnt", frame_cnt, m_frames);
      chk("drop_cnt", drop_cnt, m_drop);
      if (!np_ready && np_pixel == 3'd4) held4++;
      if (np_load) begin
        chk("load_ready", np_ready, 1);
        chk("load_expected", exp_load.size() != 0, 1);
        if (exp_load.size() != 0) begin
          load_t e;
          e = exp_load.pop_front();
          chk("load_pixel", np_pixel, e.px);
          chk("load_rgb", {np_red, np_green, np_blue}, e.rgb);
        end
        cap[np_pixel] = {np_red, np_green, np_blue};
      end
      if (np_go) begin
        chk("go_expected", exp_go > 0, 1);
        chk("go_after_loads", exp_load.size(), 0);
        chk("go_no_load", np_load, 0);
        if (exp_go > 0) exp_go--;
      end
    end
  end

  // Strand controller model: drops ready after each go, optional stalls.
  bit rnd_ready = 0;
  bit hold_p4 = 0;
  int low_len = 0;

  initial begin : ctrl
    int low;
    bit g, p3;
    low = 0;
    forever begin
      @(negedge CLOCK_50);
      g  = np_go;
      p3 = np_load && np_pixel == 3'd3;
      @(posedge CLOCK_50);
      #1;
      if (g) low = (low_len > 0) ? low_len : $urandom_range(1, 4);
      else if (p3 && hold_p4) begin
        low = 3;
        hold_p4 = 0;
      end
      if (low > 0) begin
        np_ready = 1'b0;
        low--;
      end else begin
        np_ready = rnd_ready ? ($urandom_range(0, 5) != 0) : 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic wr(input int p, input logic [23:0] c);
    wr_en    = 1'b1;
    wr_pixel = 3'(p);
    {wr_red, wr_green, wr_blue} = c;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || pending) && n < 300) begin
      cyc();
      n++;
    end
    chk({nm, "_idle_timeout"}, n < 300, 1);
  endtask

  task automatic wait_go(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!np_go && n < 100);
    chk({nm, "_go_timeout"}, np_go, 1);
    cyc();
  endtask

  initial begin
    int n, nl;
    #35;
    chk("rst_outputs", {np_load, np_go, busy, pending, np_pixel}, 0);
    chk("rst_counts", {frame_cnt, drop_cnt}, 0);
    @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;

    nl = 0;
    repeat (100) begin
      @(negedge CLOCK_50);
      if (np_load || np_go) nl++;
    end
    chk("t1_no_activity", nl, 0);
    chk("t1_rgb_zero", {np_red, np_green, np_blue}, 0);
    cyc();

    for (int k = 0; k < 8; k++) begin
      wr(k, {8'(k * 16), 8'(k * 8), 8'(k)});
      cyc();
    end
    commit = 1'b1;
    cyc();
    n = 0;
    nl = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
      if (np_load) nl++;
    end while (!np_go && n < 50);
    chk("t2_go_latency", n, 10);
    chk("t2_load_count", nl, 8);
    chk("t2_busy_at_go", busy, 1);
    cyc();
    wait_idle("t2");
    chk("t2_frame_cnt", frame_cnt, 1);
    for (int k = 0; k < 8; k++) begin
      chk("t2_pixel", cap[k], {8'(k * 16), 8'(k * 8), 8'(k)});
    end

    hold_p4 = 1;
    commit = 1'b1;
    cyc();
    wait_idle("t3");
    chk("t3_hold_cycles", held4, 3);
    chk("t3_frame_cnt", frame_cnt, 2);

    low_len = 8;
    commit = 1'b1;
    cyc();
    wait_go("t4");
    wr(2, 24'hFF0000);
    commit = 1'b1;
    cyc();
    commit = 1'b1;
    cyc();
    commit = 1'b1;
    cyc();
    chk("t4_pending", pending, 1);
    chk("t4_drop_cnt", drop_cnt, 2);
    low_len = 0;
    wait_idle("t4");
    chk("t4_px2", cap[2], 24'hFF0000);
    chk("t4_frame_cnt", frame_cnt, 4);

    wr(7, 24'h00FF00);
    commit = 1'b1;
    cyc();
    wr(6, 24'h123456);
    cyc();
    wait_idle("t5");
    chk("t5_px7", cap[7], 24'h00FF00);
    chk("t5_px6_fwd", cap[6], 24'h123456);

    commit = 1'b1;
    cyc();
    n = 0;
    nl = 0;
    while (nl < 3 && n < 50) begin
      @(negedge CLOCK_50);
      n++;
      if (np_load) nl++;
    end
    chk("t6_loads", nl, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_strobes", {np_load, np_go, busy, pending}, 0);
    chk("t6_rst_data", {np_pixel, np_red, np_green, np_blue}, 0);
    chk("t6_rst_counts", {frame_cnt, drop_cnt}, 0);
    @(posedge CLOCK_50);
    #3 reset_n = 1'b1;
    nl = 0;
    repeat (30) begin
      @(negedge CLOCK_50);
      if (np_go || np_load) nl++;
    end
    chk("t6_no_go", nl, 0);
    cyc();

    rnd_ready = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 7), 24'($urandom));
      if ($urandom_range(0, 9) == 0) commit = 1'b1;
      if ($urandom_range(0, 49) == 0) low_len = $urandom_range(0, 6);
      cyc();
    end
    rnd_ready = 0;
    low_len = 0;
    wait_idle("drain");
    chk("drain_loads_left", exp_load.size(), 0);
    chk("drain_go_left", exp_go, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
